sdram_prefetch_buffer: RTL and testbench
========================================

SDRAM_PREFETCH_BUFFER -- requirements
Module: sdram_prefetch_buffer

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, words per prefetch line; power of two; only 8 is supported.
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports wb_stb_i, wb_cyc_i, wb_we_i  input  1 each  Wishbone request from the bus arbiter (already address-decoded).
REQ-005 SHALL have ports wb_sel_i  input  4  byte enables; wb_adr_i  input  32  byte address; wb_dat_i  input  32  write data.
REQ-006 SHALL have ports wb_ack_o  output  1  transfer ack; wb_dat_o  output  32  read data.
REQ-007 SHALL have ports ctrl_in_valid  output  1, ctrl_rw  output  1 (1=write), ctrl_addr  output  23, ctrl_data_in  output  32, ctrl_sel  output  4  SDRAM controller command.
REQ-008 SHALL have ports ctrl_busy  input  1, ctrl_out_valid  input  1, ctrl_data_out  input  32  SDRAM controller status and read return.
REQ-009 SHALL have port inv_i  input  1  line invalidate (e.g. DMA wrote SDRAM).
REQ-010 SHALL have ports hit_cnt, miss_cnt  output  16 each  saturating statistics.

Function
REQ-011 SHALL hold one line: tag = adr[22:5], 8 data words, 1 valid bit; word index = adr[4:2]; adr[1:0] ignored.
REQ-012 SHALL use states IDLE, HIT_ACK, FILL_REQ, FILL_WAIT, RD_ACK, WR_REQ, WR_ACK.
REQ-013 SHALL treat a request as present when wb_stb_i & wb_cyc_i in IDLE.
REQ-014 SHALL on a read with valid & tag match go IDLE->HIT_ACK; wb_ack_o=1 for exactly one cycle in HIT_ACK with wb_dat_o = buffered word; 1-cycle latency; hit_cnt+1.
REQ-015 SHALL on a read miss clear valid, latch base = {adr[22:5],5'b0}, clear fill counter k, go FILL_REQ; miss_cnt+1.
REQ-016 SHALL in FILL_REQ drive ctrl_in_valid=1, ctrl_rw=0, ctrl_addr=base+4*k; command accepted on a cycle with ctrl_busy=0, then FILL_WAIT.
REQ-017 SHALL in FILL_WAIT store ctrl_data_out into word k on ctrl_out_valid; if k=7 go RD_ACK, else k+1 and FILL_REQ; one outstanding read at a time.
REQ-018 SHALL in RD_ACK set valid (unless an invalidate occurred during the fill), assert wb_ack_o one cycle with the requested word, return IDLE.
REQ-019 SHALL on a write go WR_REQ driving ctrl_in_valid=1, ctrl_rw=1, ctrl_addr=adr[22:0], ctrl_data_in=wb_dat_i, ctrl_sel=wb_sel_i until accepted (ctrl_busy=0), then WR_ACK with one-cycle wb_ack_o, then IDLE.
REQ-020 SHALL on write acceptance, if valid & tag match, merge wb_dat_i into the buffered word per byte lane of wb_sel_i (write-through, no allocate on miss).
REQ-021 SHALL drive ctrl_in_valid=0 in every state other than FILL_REQ and WR_REQ; ctrl_sel=4'h0 on reads.
REQ-022 SHALL on inv_i clear valid next cycle in any state; inv_i coincident with a hit in IDLE serves that hit from the buffer, then invalidates.
REQ-023 SHALL keep wb_ack_o low in IDLE so no request is acked twice; a stb held after ack starts a new transfer.
REQ-024 SHALL saturate hit_cnt and miss_cnt at 16'hFFFF.
REQ-025 SHALL keep wb_dat_o = 0 when wb_ack_o = 0.

Reset
REQ-026 SHALL on rst enter IDLE, clear valid, k, hit_cnt, miss_cnt; wb_ack_o=0, wb_dat_o=0, ctrl_in_valid=0, ctrl_rw=0, ctrl_addr=0, ctrl_data_in=0, ctrl_sel=0.
REQ-027 SHALL on rst mid-fill abandon the fill; late ctrl_out_valid after reset is ignored in IDLE, buffer invalid.

Verification
REQ-028 Read 0x0000_0044 cold -> 8 reads 0x40..0x5C issued in order, ack after 8th return with word 1, miss_cnt=1.
REQ-029 Then read 0x0000_0058 -> ack 1 cycle after request, no ctrl_in_valid, hit_cnt=1.
REQ-030 Write 0xAABBCCDD sel=4'b0011 to 0x48 (line valid) -> controller write issued, readback of 0x48 hits with lanes [15:0]=0xCCDD, upper bytes unchanged.
REQ-031 ctrl_busy held high 5 cycles during FILL_REQ -> ctrl_in_valid and ctrl_addr stable all 5 cycles, single command accepted.
REQ-032 inv_i pulse during fill of line 0x100 -> read acked with correct data; next read of 0x104 misses and refills.
REQ-033 rst asserted in FILL_WAIT after 3 words -> all outputs zero next cycle; next read of same address misses, miss_cnt=1.

Source files
------------

// File: rtl/sdram_prefetch_buffer.sv
// Single-line read prefetch buffer between a Wishbone slave port and an SDRAM controller.
// Read hits ack one cycle after the request; misses fill all 8 words first; writes go straight through.
module sdram_prefetch_buffer #(
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        ctrl_in_valid,
    output logic        ctrl_rw,
    output logic [22:0] ctrl_addr,
    output logic [31:0] ctrl_data_in,
    output logic [3:0]  ctrl_sel,
    input  logic        ctrl_busy,
    input  logic        ctrl_out_valid,
    input  logic [31:0] ctrl_data_out,
    input  logic        inv_i,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);

    typedef enum logic [2:0] {
        IDLE, HIT_ACK, FILL_REQ, FILL_WAIT, RD_ACK, WR_REQ, WR_ACK
    } state_t;

    state_t      state, state_nxt;
    logic        valid;
    logic [17:0] tag;
    logic [2:0]  k;
    logic [22:0] req_adr;
    logic [31:0] req_dat;
    logic [3:0]  req_sel;
    logic        inv_seen;
    logic [31:0] line_mem [LINE_WORDS];

    logic req, hit, wr_hit;
    logic unused_adr;

    assign req        = wb_stb_i & wb_cyc_i;
    assign hit        = valid && (tag == wb_adr_i[22:5]);
    assign wr_hit     = valid && (tag == req_adr[22:5]);
    assign unused_adr = ^{wb_adr_i[31:23], wb_adr_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        wb_ack_o      = 1'b0;
        wb_dat_o      = 32'h0;
        ctrl_in_valid = 1'b0;
        ctrl_rw       = 1'b0;
        ctrl_addr     = 23'h0;
        ctrl_data_in  = 32'h0;
        ctrl_sel      = 4'h0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (wb_we_i)  state_nxt = WR_REQ;
                    else if (hit) state_nxt = HIT_ACK;
                    else          state_nxt = FILL_REQ;
                end
            end
            HIT_ACK, RD_ACK: begin
                wb_ack_o  = 1'b1;
                wb_dat_o  = line_mem[req_adr[4:2]];
                state_nxt = IDLE;
            end
            FILL_REQ: begin
                ctrl_in_valid = 1'b1;
                ctrl_addr     = {tag, k, 2'b00};
                if (!ctrl_busy) state_nxt = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (ctrl_out_valid) state_nxt = (k == 3'd7) ? RD_ACK : FILL_REQ;
            end
            WR_REQ: begin
                ctrl_in_valid = 1'b1;
                ctrl_rw       = 1'b1;
                ctrl_addr     = req_adr;
                ctrl_data_in  = req_dat;
                ctrl_sel      = req_sel;
                if (!ctrl_busy) state_nxt = WR_ACK;
            end
            WR_ACK: begin
                wb_ack_o  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            tag      <= 18'h0;
            k        <= 3'd0;
            req_adr  <= 23'h0;
            req_dat  <= 32'h0;
            req_sel  <= 4'h0;
            inv_seen <= 1'b0;
            hit_cnt  <= 16'h0;
            miss_cnt <= 16'h0;
        end else begin
            if (inv_i) inv_seen <= 1'b1;
            case (state)
                IDLE: begin
                    if (req) begin
                        req_adr <= wb_adr_i[22:0];
                        req_dat <= wb_dat_i;
                        req_sel <= wb_sel_i;
                        if (!wb_we_i) begin
                            if (hit) begin
                                if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                            end else begin
                                valid    <= 1'b0;
                                tag      <= wb_adr_i[22:5];
                                k        <= 3'd0;
                                inv_seen <= 1'b0;
                                if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
                            end
                        end
                    end
                end
                FILL_WAIT: begin
                    if (ctrl_out_valid && k != 3'd7) k <= k + 3'd1;
                end
                RD_ACK: valid <= !inv_seen;
                default: ;
            endcase
            // Invalidate wins over everything, including the fill completing this cycle.
            if (inv_i) valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL_WAIT && ctrl_out_valid) begin
            line_mem[k] <= ctrl_data_out;
        end else if (state == WR_REQ && !ctrl_busy && wr_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (req_sel[b]) line_mem[req_adr[4:2]][8*b +: 8] <= req_dat[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sdram_prefetch_buffer.sv
// Directed bench for sdram_prefetch_buffer with a one-command-at-a-time SDRAM responder.
module tb_sdram_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_stb_i, wb_cyc_i, wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i, wb_dat_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        ctrl_in_valid, ctrl_rw;
    logic [22:0] ctrl_addr;
    logic [31:0] ctrl_data_in;
    logic [3:0]  ctrl_sel;
    logic        ctrl_busy, ctrl_out_valid;
    logic [31:0] ctrl_data_out;
    logic        inv_i;
    logic [15:0] hit_cnt, miss_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sdram_prefetch_buffer #(.LINE_WORDS(8)) dut (
        .clk(clk), .rst(rst),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
        .ctrl_in_valid(ctrl_in_valid), .ctrl_rw(ctrl_rw), .ctrl_addr(ctrl_addr),
        .ctrl_data_in(ctrl_data_in), .ctrl_sel(ctrl_sel),
        .ctrl_busy(ctrl_busy), .ctrl_out_valid(ctrl_out_valid), .ctrl_data_out(ctrl_data_out),
        .inv_i(inv_i), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Commands accepted by the SDRAM model, in order.
    logic [22:0] log_addr [$];
    logic        log_rw   [$];
    logic [31:0] log_dat  [$];
    logic [3:0]  log_sel  [$];
    logic [31:0] wmem [int];
    bit          pend;
    logic [22:0] pend_addr;
    logic [31:0] merged;

    function automatic logic [31:0] mdl(input logic [22:0] a);
        if (wmem.exists(int'(a[22:2]))) return wmem[int'(a[22:2])];
        return 32'hC0DE_0000 | {9'h0, a};
    endfunction

    initial begin : responder
        ctrl_out_valid = 1'b0;
        ctrl_data_out  = 32'h0;
        pend           = 1'b0;
        pend_addr      = 23'h0;
        forever begin
            @(negedge clk);
            #1;
            ctrl_out_valid = 1'b0;
            ctrl_data_out  = 32'h0;
            if (pend) begin
                ctrl_out_valid = 1'b1;
                ctrl_data_out  = mdl(pend_addr);
                pend           = 1'b0;
            end
            if (ctrl_in_valid === 1'b1 && !ctrl_busy) begin
                log_addr.push_back(ctrl_addr);
                log_rw.push_back(ctrl_rw);
                log_dat.push_back(ctrl_data_in);
                log_sel.push_back(ctrl_sel);
                if (ctrl_rw) begin
                    merged = mdl(ctrl_addr);
                    for (int b = 0; b < 4; b++)
                        if (ctrl_sel[b]) merged[8*b +: 8] = ctrl_data_in[8*b +: 8];
                    wmem[int'(ctrl_addr[22:2])] = merged;
                end else begin
                    pend      = 1'b1;
                    pend_addr = ctrl_addr;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
        @(negedge clk);
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
    endtask

    task automatic wait_ack(output logic [31:0] data, output int cycles);
        data   = 32'hDEAD_BEEF;
        cycles = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wb_ack_o === 1'b1) begin
                data   = wb_dat_o;
                cycles = i + 1;
                break;
            end
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        check("ack_seen", {31'h0, cycles > 0}, 32'h1);
    endtask

    logic [31:0] d;
    int          c;
    int          n0;

    initial begin : stim
        rst = 1'b1;
        wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0; wb_sel_i = 0; wb_adr_i = 0; wb_dat_i = 0;
        ctrl_busy = 1'b0;
        inv_i     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack",      {31'h0, wb_ack_o}, 32'h0);
        check("rst_dat",      wb_dat_o, 32'h0);
        check("rst_in_valid", {31'h0, ctrl_in_valid}, 32'h0);
        check("rst_addr",     {9'h0, ctrl_addr}, 32'h0);
        check("rst_hit",      {16'h0, hit_cnt}, 32'h0);
        check("rst_miss",     {16'h0, miss_cnt}, 32'h0);
        rst = 1'b0;

        // Cold read of 0x44: full fill of line 0x40, word 1 returned.
        n0 = log_addr.size();
        start_req(1'b0, 32'h0000_0044, 32'h0, 4'h0);
        wait_ack(d, c);
        check("miss_data", d, 32'hC0DE_0044);
        check("miss_ncmd", log_addr.size() - n0, 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("fill_addr", {9'h0, log_addr[n0+i]}, 32'h40 + 32'(4*i));
            check("fill_rw",   {31'h0, log_rw[n0+i]}, 32'h0);
        end
        check("miss_cnt_1", {16'h0, miss_cnt}, 32'd1);
        check("hit_cnt_0",  {16'h0, hit_cnt},  32'd0);
        @(negedge clk);
        check("idle_ack", {31'h0, wb_ack_o}, 32'h0);
        check("idle_dat", wb_dat_o, 32'h0);

        // Hit on 0x58.
        n0 = log_addr.size();
        start_req(1'b0, 32'h0000_0058, 32'h0, 4'h0);
        wait_ack(d, c);
        check("hit_data", d, 32'hC0DE_0058);
        check("hit_lat",  c, 32'd1);
        check("hit_ncmd", log_addr.size() - n0, 32'd0);
        check("hit_cnt_1", {16'h0, hit_cnt}, 32'd1);

        // Byte-lane write-through into the valid line.
        n0 = log_addr.size();
        start_req(1'b1, 32'h0000_0048, 32'hAABB_CCDD, 4'b0011);
        wait_ack(d, c);
        check("wr_ncmd", log_addr.size() - n0, 32'd1);
        check("wr_rw",   {31'h0, log_rw[n0]}, 32'h1);
        check("wr_addr", {9'h0, log_addr[n0]}, 32'h48);
        check("wr_dat",  log_dat[n0], 32'hAABB_CCDD);
        check("wr_sel",  {28'h0, log_sel[n0]}, 32'h3);
        start_req(1'b0, 32'h0000_0048, 32'h0, 4'h0);
        wait_ack(d, c);
        check("wr_merge_data", d, 32'hC0DE_CCDD);
        check("wr_merge_lat",  c, 32'd1);
        check("hit_cnt_2", {16'h0, hit_cnt}, 32'd2);

        // Controller busy for 5 cycles while the first fill command is pending.
        ctrl_busy = 1'b1;
        n0 = log_addr.size();
        start_req(1'b0, 32'h0000_0080, 32'h0, 4'h0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("busy_valid", {31'h0, ctrl_in_valid}, 32'h1);
            check("busy_addr",  {9'h0, ctrl_addr}, 32'h80);
            check("busy_sel",   {28'h0, ctrl_sel}, 32'h0);
            @(negedge clk);
        end
        check("busy_nolog", log_addr.size() - n0, 32'd0);
        ctrl_busy = 1'b0;
        wait_ack(d, c);
        check("busy_data",  d, 32'hC0DE_0080);
        check("busy_ncmd",  log_addr.size() - n0, 32'd8);
        check("busy_first", {9'h0, log_addr[n0]}, 32'h80);
        check("busy_second", {9'h0, log_addr[n0+1]}, 32'h84);
        check("miss_cnt_2", {16'h0, miss_cnt}, 32'd2);

        // Invalidate during a fill: data still returned, line not kept.
        start_req(1'b0, 32'h0000_0100, 32'h0, 4'h0);
        repeat (4) @(negedge clk);
        inv_i = 1'b1;
        @(negedge clk);
        inv_i = 1'b0;
        wait_ack(d, c);
        check("inv_fill_data", d, 32'hC0DE_0100);
        n0 = log_addr.size();
        start_req(1'b0, 32'h0000_0104, 32'h0, 4'h0);
        wait_ack(d, c);
        check("inv_refill_ncmd",  log_addr.size() - n0, 32'd8);
        check("inv_refill_first", {9'h0, log_addr[n0]}, 32'h100);
        check("inv_refill_data",  d, 32'hC0DE_0104);
        check("miss_cnt_4", {16'h0, miss_cnt}, 32'd4);

        // Invalidate coincident with a hit: served from the buffer, then gone.
        n0 = log_addr.size();
        start_req(1'b0, 32'h0000_0108, 32'h0, 4'h0);
        inv_i = 1'b1;
        wait_ack(d, c);
        inv_i = 1'b0;
        check("invhit_data", d, 32'hC0DE_0108);
        check("invhit_lat",  c, 32'd1);
        check("invhit_ncmd", log_addr.size() - n0, 32'd0);
        check("hit_cnt_3", {16'h0, hit_cnt}, 32'd3);
        n0 = log_addr.size();
        start_req(1'b0, 32'h0000_010C, 32'h0, 4'h0);
        wait_ack(d, c);
        check("invhit_after_ncmd", log_addr.size() - n0, 32'd8);
        check("invhit_after_data", d, 32'hC0DE_010C);
        check("miss_cnt_5", {16'h0, miss_cnt}, 32'd5);

        // Reset in FILL_WAIT after three words have returned.
        n0 = log_addr.size();
        start_req(1'b0, 32'h0000_0200, 32'h0, 4'h0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (log_addr.size() - n0 >= 4) break;
        end
        check("midfill_reached", log_addr.size() - n0, 32'd4);
        rst = 1'b1;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        @(negedge clk);
        check("mrst_ack",      {31'h0, wb_ack_o}, 32'h0);
        check("mrst_dat",      wb_dat_o, 32'h0);
        check("mrst_in_valid", {31'h0, ctrl_in_valid}, 32'h0);
        check("mrst_rw",       {31'h0, ctrl_rw}, 32'h0);
        check("mrst_addr",     {9'h0, ctrl_addr}, 32'h0);
        check("mrst_data_in",  ctrl_data_in, 32'h0);
        check("mrst_sel",      {28'h0, ctrl_sel}, 32'h0);
        check("mrst_hit",      {16'h0, hit_cnt}, 32'h0);
        check("mrst_miss",     {16'h0, miss_cnt}, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mrst_idle_ack", {31'h0, wb_ack_o}, 32'h0);
        n0 = log_addr.size();
        start_req(1'b0, 32'h0000_0200, 32'h0, 4'h0);
        wait_ack(d, c);
        check("mrst_refill_ncmd", log_addr.size() - n0, 32'd8);
        check("mrst_refill_data", d, 32'hC0DE_0200);
        check("mrst_miss_1", {16'h0, miss_cnt}, 32'd1);
        check("mrst_hit_0",  {16'h0, hit_cnt},  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
